// File: rtl/bcd_display_scan.sv
// Scans a latched 6-digit BCD measurement onto a common-anode 7-segment display.
// A frame is six slots; each slot opens with a few all-off cycles so one digit's pattern never ghosts onto the next.
module bcd_display_scan #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 8
) (
    input  logic        clk,
    input  logic        Rst_n,
    input  logic [23:0] data_in,
    input  logic        data_valid,
    input  logic        ovf_in,
    output logic [7:0]  seg,
    output logic [5:0]  an,
    output logic        frame_sync,
    output logic        o_dbg_state
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam bit HAS_BLANK = (BLANK_CYC > 0);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [24:0]      r_shadow;
    logic [24:0]      r_disp;
    logic             r_pend;
    logic             r_have;
    logic [7:0]       r_seg;
    logic [5:0]       r_an;
    logic             r_fsync;

    logic             w_eos;
    logic             w_eof;
    logic [3:0]       w_dig [6];
    logic [5:0]       w_lead_zero;
    logic [3:0]       w_cur;
    logic             w_cur_blank;
    logic [5:0]       w_an_drive;
    logic [7:0]       w_pattern;

    function automatic logic [7:0] seg_decode(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'h86;
        endcase
        return s;
    endfunction

    assign w_eos = (r_cnt == CNT_LAST);
    assign w_eof = w_eos && (r_idx == 3'd5);

    // w_lead_zero[k] is set when digit k and every digit above it are zero.
    always_comb begin : lead_zero_blk
        logic zero_run;
        zero_run = 1'b1;
        w_lead_zero = '0;
        for (int k = 5; k >= 0; k--) begin
            w_dig[k] = r_disp[4*k +: 4];
            zero_run = zero_run & (w_dig[k] == 4'd0);
            w_lead_zero[k] = zero_run;
        end
    end

    always_comb begin
        w_cur       = 4'd0;
        w_cur_blank = 1'b0;
        w_an_drive  = 6'h3F;
        case (r_idx)
            3'd0: begin w_cur = w_dig[0]; w_cur_blank = 1'b0;           w_an_drive = 6'b111110; end
            3'd1: begin w_cur = w_dig[1]; w_cur_blank = w_lead_zero[1]; w_an_drive = 6'b111101; end
            3'd2: begin w_cur = w_dig[2]; w_cur_blank = w_lead_zero[2]; w_an_drive = 6'b111011; end
            3'd3: begin w_cur = w_dig[3]; w_cur_blank = w_lead_zero[3]; w_an_drive = 6'b110111; end
            3'd4: begin w_cur = w_dig[4]; w_cur_blank = w_lead_zero[4]; w_an_drive = 6'b101111; end
            3'd5: begin w_cur = w_dig[5]; w_cur_blank = w_lead_zero[5]; w_an_drive = 6'b011111; end
            default: begin w_cur = 4'd0; w_cur_blank = 1'b1; w_an_drive = 6'h3F; end
        endcase
    end

    always_comb begin
        if (r_disp[24]) begin
            w_pattern = 8'hBF;
        end else if (w_cur > 4'd9) begin
            w_pattern = 8'h86;
        end else if (w_cur_blank) begin
            w_pattern = 8'hFF;
        end else begin
            w_pattern = seg_decode(w_cur);
        end
    end

    // data_valid is a one-cycle strobe with no back-pressure: every strobe is accepted and
    // overwrites the shadow; the display register only changes at end-of-frame.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt    <= '0;
            r_idx    <= 3'd0;
            r_shadow <= '0;
            r_disp   <= '0;
            r_pend   <= 1'b0;
            r_have   <= 1'b0;
            r_fsync  <= 1'b0;
        end else begin
            r_cnt <= w_eos ? '0 : r_cnt + CNT_W'(1);
            if (w_eos) begin
                r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
            end
            r_fsync <= w_eof && r_pend;
            if (w_eof && r_pend) begin
                r_disp <= r_shadow;
                r_have <= 1'b1;
            end
            if (data_valid) begin
                r_shadow <= {ovf_in, data_in};
                r_pend   <= 1'b1;
            end else if (w_eof) begin
                r_pend   <= 1'b0;
            end
        end
    end

    // Outputs are registered from the current state, so they trail the state by one cycle.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_BLANK;
            r_an    <= 6'h3F;
            r_seg   <= 8'hFF;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (!HAS_BLANK || (r_cnt == BLANK_LAST)) begin
                        r_state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (w_eos && HAS_BLANK) begin
                        r_state <= ST_BLANK;
                    end
                end
                default: r_state <= ST_BLANK;
            endcase
            if ((r_state == ST_DRIVE) && r_have) begin
                r_an  <= w_an_drive;
                r_seg <= w_pattern;
            end else begin
                r_an  <= 6'h3F;
                r_seg <= 8'hFF;
            end
        end
    end

    assign seg         = r_seg;
    assign an          = r_an;
    assign frame_sync  = r_fsync;
    assign o_dbg_state = r_state;

endmodule
